multicycle_controller: RTL

Multi-cycle successor to the single-cycle MIPS `controller`. It keeps that controller's instruction set and its overflow-to-GPR30 behaviour. Decoding is sequenced over IF/ID/EX/MEM/WB states, so one ALU and one memory port can be shared across cycles. It sits beside the multi-cycle datapath, drives every datapath enable/select, and adds a data-memory ready handshake and a retired-instruction counter.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/instr_decode.sv | 62 ++++++
 rtl/multicycle_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU/extender encodings and controller state types
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;
    typedef enum logic [2:0] {S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_RTYPE, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILL} iclass_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational decode of the latched opcode/funct into class and datapath selects
module instr_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] fn,
    output iclass_t    cls,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       is_add,
    output logic       legal
);
    always_comb begin
        cls        = C_ILL;
        alu_op     = ALU_ADD;
        ext_op     = EXT_ZERO;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        is_add     = 1'b0;
        case (op)
            OP_RTYPE: begin
                cls     = (fn == FN_ADD || fn == FN_ADDU || fn == FN_SUBU || fn == FN_SLT) ? C_RTYPE : C_ILL;
                alu_op  = fn == FN_SUBU ? ALU_SUB : fn == FN_SLT ? ALU_SLT : ALU_ADD;
                reg_dst = 1'b1;
                is_add  = fn == FN_ADD;
            end
            OP_ORI: begin
                cls     = C_ORI;
                alu_op  = ALU_OR;
                alu_src = 1'b1;
            end
            OP_LUI: begin
                cls     = C_LUI;
                alu_op  = ALU_LUI;
                alu_src = 1'b1;
                ext_op  = EXT_UPPER;
            end
            OP_LW: begin
                cls        = C_LW;
                alu_src    = 1'b1;
                ext_op     = EXT_SIGN;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                cls     = C_SW;
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
            end
            OP_BEQ: begin
                cls    = C_BEQ;
                alu_op = ALU_SUB;
            end
            OP_J:    cls = C_J;
            default: cls = C_ILL;
        endcase
    end
    assign legal = cls != C_ILL;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: IF/ID/EX/MEM/WB sequencer driving the shared-ALU MIPS datapath
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32,
    parameter bit MEM_HS  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               overflow,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               MemWrite,
    output logic               Branch,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         ExtOp,
    output logic               J,
    output logic               WriteToGPR_30,
    output logic               illegal,
    output logic               instr_done,
    output logic [CNT_W-1:0]   instr_count
);
    state_t     state, next;
    logic [5:0] op_q, fn_q;
    logic       ovf_q;
    iclass_t    cls;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic       alu_src, reg_dst, mem_to_reg, is_add, legal;
    logic       mem_done;

    instr_decode u_dec (
        .op(op_q), .fn(fn_q), .cls(cls), .alu_op(alu_op), .ext_op(ext_op), .alu_src(alu_src),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .is_add(is_add), .legal(legal)
    );

    assign mem_done = !MEM_HS || mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= '0;
            fn_q        <= '0;
            ovf_q       <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next;
            if (IRWrite) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (state == S_EX) ovf_q <= overflow;
            if (instr_done) instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        next          = state;
        PCWrite       = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrc        = 1'b0;
        MemtoReg      = 1'b0;
        MemWrite      = 1'b0;
        Branch        = 1'b0;
        ALUOp         = '0;
        ExtOp         = EXT_ZERO;
        J             = 1'b0;
        WriteToGPR_30 = 1'b0;
        illegal       = 1'b0;
        instr_done    = 1'b0;
        case (state)
            S_IDLE: next = S_IF;
            S_IF: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                next    = S_ID;
            end
            S_ID: begin
                illegal    = !legal;
                PCWrite    = cls == C_J;
                J          = cls == C_J;
                instr_done = cls == C_J;
                next       = (!legal || cls == C_J) ? S_IF : S_EX;
            end
            S_EX: begin
                ALUOp      = ALUOP_W'(alu_op);
                ALUSrc     = alu_src;
                ExtOp      = ext_op;
                Branch     = cls == C_BEQ;
                instr_done = cls == C_BEQ;
                next       = cls == C_BEQ ? S_IF : (cls == C_LW || cls == C_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // Address operands stay on the ALU for the whole access
                ALUOp      = ALUOP_W'(alu_op);
                ALUSrc     = alu_src;
                ExtOp      = ext_op;
                MemWrite   = cls == C_SW;
                instr_done = cls == C_SW && mem_done;
                next       = !mem_done ? S_MEM : cls == C_SW ? S_IF : S_WB;
            end
            S_WB: begin
                RegDst        = reg_dst;
                MemtoReg      = mem_to_reg;
                WriteToGPR_30 = is_add && ovf_q;
                RegWrite      = !(is_add && ovf_q);
                instr_done    = 1'b1;
                next          = S_IF;
            end
            default: next = S_IDLE;
        endcase
    end
endmodule
